// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave cook-timer controller:
// FSM state encoding, M:SS time record, BCD digit limits and the
// quick-start increment.
package microwave_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_COOK  = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // Largest value of a units digit (minutes or seconds) and of the tens-of-seconds digit.
  localparam logic [3:0] UNITS_MAX = 4'd9;
  localparam logic [2:0] TENS_MAX  = 3'd5;

  // Displayed cook time M:SS, one BCD digit per field.
  typedef struct packed {
    logic [3:0] mins;
    logic [2:0] tens;
    logic [3:0] units;
  } bcd_time_t;

  localparam bcd_time_t ZERO_TIME        = '{mins: 4'd0, tens: 3'd0, units: 4'd0};
  localparam bcd_time_t QUICK_START_TIME = '{mins: 4'd0, tens: 3'd3, units: 4'd0};
  localparam bcd_time_t MAX_TIME         = '{mins: UNITS_MAX, tens: TENS_MAX, units: UNITS_MAX};

  // Adds 30 s to an M:SS time, saturating at 9:59. Units never change;
  // tens wrap modulo 6 with a carry into minutes.
  function automatic bcd_time_t add_30s(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.tens < 3'd3) begin
      r.tens = t.tens + 3'd3;
    end else if (t.mins == UNITS_MAX) begin
      r = MAX_TIME;
    end else begin
      r.mins = t.mins + 4'd1;
      r.tens = t.tens - 3'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_countdown.sv
// One-second decrement of the M:SS cook time with borrow from units to
// tens to minutes, plus zero detection on the current and decremented time.
// 0:00 decrements to itself so the counter can never wrap.
module bcd_countdown
  import microwave_pkg::*;
(
  input  logic [3:0] mins_in,
  input  logic [2:0] tens_in,
  input  logic [3:0] units_in,
  output logic [3:0] mins_dec,
  output logic [2:0] tens_dec,
  output logic [3:0] units_dec,
  output logic       is_zero,
  output logic       dec_is_zero
);

  // Borrow chain: units first, then tens, then minutes.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    mins_dec  = mins_in;
    tens_dec  = tens_in;
    units_dec = units_in;
    if (units_in != 4'd0) begin
      units_dec = units_in - 4'd1;
    end else if (tens_in != 3'd0) begin
      tens_dec  = tens_in - 3'd1;
      units_dec = UNITS_MAX;
    end else if (mins_in != 4'd0) begin
      mins_dec  = mins_in - 4'd1;
      tens_dec  = TENS_MAX;
      units_dec = UNITS_MAX;
    end
  end

  assign is_zero     = (mins_in == 4'd0) && (tens_in == 3'd0) && (units_in == 4'd0);
  assign dec_is_zero = (mins_dec == 4'd0) && (tens_dec == 3'd0) && (units_dec == 4'd0);

endmodule

// File: rtl/microwave_controller.sv
// Microwave cook-timer sequencer: keypad digit entry, door interlock,
// 1-second prescaler and the IDLE/ENTRY/COOK/PAUSE/DONE state machine.
// Optional feature macro QUICK_START_EN: start in IDLE loads 0:30 and
// cooks; start while cooking adds 30 s (saturating at 9:59).
module microwave_controller
  import microwave_pkg::*;
#(
  parameter int TICK_DIV = 100
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop,
  input  logic       door_closed,
  output logic [3:0] minutes_units,
  output logic [2:0] seconds_tens,
  output logic [3:0] seconds_units,
  output logic       magnetron_on,
  output logic       done,
  output logic [2:0] state
);

  localparam int             PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);

`ifdef QUICK_START_EN
  localparam logic QUICK_START = 1'b1;
`else
  localparam logic QUICK_START = 1'b0;
`endif

  state_e        state_q, state_d;
  bcd_time_t     time_q, time_d, time_dec, time_shifted;
  logic [PW-1:0] presc_q, presc_d;
  logic          time_zero, dec_zero;
  logic          key_ok, tick, leave_cook;

  bcd_countdown u_countdown (
    .mins_in     (time_q.mins),
    .tens_in     (time_q.tens),
    .units_in    (time_q.units),
    .mins_dec    (time_dec.mins),
    .tens_dec    (time_dec.tens),
    .units_dec   (time_dec.units),
    .is_zero     (time_zero),
    .dec_is_zero (dec_zero)
  );

  // A key is accepted only if it is a decimal digit, the current units digit
  // can legally become a tens-of-seconds digit, and the minutes slot is free.
  assign key_ok = key_valid
               && (key_digit <= UNITS_MAX)
               && (time_q.units <= {1'b0, TENS_MAX})
               && (time_q.mins == 4'd0);

  assign time_shifted = '{mins:  {1'b0, time_q.tens},
                          tens:  time_q.units[2:0],
                          units: key_digit};

  assign tick       = (presc_q == PRESC_LAST);
  assign leave_cook = !door_closed || stop;

  // Next-state, next-time and next-prescaler decode.
  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    presc_d = presc_q;
    unique case (state_q)
      S_IDLE: begin
        if (QUICK_START && start && door_closed) begin
          state_d = S_COOK;
          time_d  = QUICK_START_TIME;
          presc_d = '0;
        end else if (key_ok) begin
          state_d = S_ENTRY;
          time_d  = time_shifted;
        end
      end

      S_ENTRY: begin
        if (stop) begin
          state_d = S_IDLE;
          time_d  = ZERO_TIME;
        end else if (start && door_closed && !time_zero) begin
          state_d = S_COOK;
          presc_d = '0;
        end else if (key_ok) begin
          time_d = time_shifted;
        end
      end

      S_COOK: begin
        // A tick is never lost to a pause: the decrement lands in the same
        // cycle the door opens or stop is pressed. Otherwise the prescaler
        // freezes on the pausing cycle so resume continues from the same count.
        if (tick) begin
          time_d  = time_dec;
          presc_d = '0;
        end else if (!leave_cook) begin
          presc_d = presc_q + PW'(1);
        end
        // Reaching 0:00 ends the cook even if the door opens on that same
        // tick, so PAUSE never holds an exhausted time.
        if (tick && dec_zero) begin
          state_d = S_DONE;
        end else if (leave_cook) begin
          state_d = S_PAUSE;
        end else if (QUICK_START && start && !tick) begin
          time_d = add_30s(time_q);
        end
      end

      S_PAUSE: begin
        if (stop) begin
          state_d = S_IDLE;
          time_d  = ZERO_TIME;
        end else if (start && door_closed) begin
          state_d = S_COOK;
        end
      end

      S_DONE: begin
        if (stop || !door_closed) begin
          state_d = S_IDLE;
        end else if (key_ok) begin
          state_d = S_ENTRY;
          time_d  = time_shifted;
        end
      end

      default: begin
        state_d = S_IDLE;
        time_d  = ZERO_TIME;
        presc_d = '0;
      end
    endcase
  end

  // State, time and prescaler registers plus the registered power and done outputs.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q      <= S_IDLE;
      time_q       <= ZERO_TIME;
      presc_q      <= '0;
      magnetron_on <= 1'b0;
      done         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values together.
      state_q      <= state_d;
      time_q       <= time_d;
      presc_q      <= presc_d;
      magnetron_on <= (state_d == S_COOK);
      done         <= (state_d == S_DONE) && (state_q != S_DONE);
    end
  end

  assign minutes_units = time_q.mins;
  assign seconds_tens  = time_q.tens;
  assign seconds_units = time_q.units;
  assign state         = state_q;

endmodule

// File: doc/microwave_controller.md
# microwave_controller

Sequencing controller for the microwave's M:SS cook timer. It accepts keypad digits, enforces the door interlock, generates the 1-second countdown tick from the system clock and decrements the BCD time with borrow. It drives the magnetron enable and signals cook completion. It sits between the keypad/door inputs and the display/power stage, replacing free-running use of the countdown timer.

## Interface
- TICK_DIV, default 100: CLK cycles per one-second tick; legal range ≥ 2.
- CLK  in  1  system clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- key_valid  in  1  one-cycle strobe; key_digit is valid.
- key_digit  in  4  BCD digit 0–9.
- start  in  1  one-cycle start/resume strobe.
- stop  in  1  one-cycle stop strobe (pause, or clear).
- door_closed  in  1  1 = door closed; level signal.
- minutes_units  out  4  displayed minutes, 0–9.
- seconds_tens  out  3  displayed tens of seconds, 0–5.
- seconds_units  out  4  displayed units of seconds, 0–9.
- magnetron_on  out  1  power enable; high only in COOK.
- done  out  1  one-cycle pulse on cook completion.
- state  out  3  current FSM state encoding.

## Operation
- **States:** IDLE, ENTRY, COOK, PAUSE, DONE.
- **Reset values:**
  - State is IDLE.
  - Time is 0:00.
  - magnetron_on and done are 0.
  - The prescaler is 0.
- **Digit entry** (IDLE or ENTRY, key_valid=1):
  - Shift left: minutes_units ← seconds_tens, seconds_tens ← seconds_units, seconds_units ← key_digit. State becomes ENTRY.
  - The key is ignored if key_digit > 9.
  - The key is ignored if current seconds_units > 5 (it could not become a tens digit).
  - The key is ignored if current minutes_units ≠ 0 (entry is full).
- **Start:**
  - ENTRY → COOK when start=1, door_closed=1 and time ≠ 0:00. The prescaler clears.
  - PAUSE → COOK when start=1 and door_closed=1. The prescaler resumes from its held value.
  - Start in any other case is ignored.
- **COOK:**
  - The prescaler counts 0..TICK_DIV-1; the terminal count is a tick.
  - **Tick decrement:**
    - If units ≠ 0: units−1.
    - Else if tens ≠ 0: tens−1, units=9.
    - Else: minutes−1, tens=5, units=9.
  - A tick taking the time to 0:00 moves to DONE, drops magnetron_on and pulses done.
  - key_valid is ignored in COOK.
- **Pause/clear:**
  - COOK → PAUSE on door_closed=0 or stop=1. Time and prescaler hold.
  - PAUSE + stop → IDLE, time cleared to 0:00.
  - ENTRY + stop → IDLE, time cleared to 0:00.
- **DONE:**
  - Holds 0:00.
  - stop=1 or door_closed=0 → IDLE.
  - key_valid with a legal digit → ENTRY with that digit in seconds_units.
- **Priority** for simultaneous events in one cycle: door open > stop > tick > start > key.
  - Example: a tick coincident with door open still decrements, then the state enters PAUSE.
- **Reset mid-operation:** asynchronous return to reset values. magnetron_on drops immediately, with no wait for a clock edge.

## Timing
- All outputs are registered.
- Inputs are sampled on the rising edge of CLK.
- magnetron_on rises the cycle after start is sampled.
- The first decrement occurs TICK_DIV cycles after COOK entry from ENTRY.
- done is high for exactly one cycle, coincident with the first cycle of DONE. magnetron_on is 0 in that cycle.
- Door-open response: magnetron_on is 0 in the cycle after door_closed=0 is sampled.
- Prescaler width: $clog2(TICK_DIV).

## Configuration
- QUICK_START_EN defined:
  - start in IDLE with door_closed=1 loads 0:30 and enters COOK.
  - start in COOK adds 30 s, saturating at 9:59.
- QUICK_START_EN undefined: start in IDLE and start in COOK are ignored.

## Structure
- Package microwave_pkg holds:
  - the state enumeration;
  - the BCD limit constants (units max 9, tens max 5);
  - the quick-start constant (0:30).
- Sub-module bcd_countdown holds the M:SS decrement, the borrow chain and the zero detect.
- microwave_controller holds the FSM, the entry shifter and the prescaler.

## Test plan
- Keys 1,3,0, then start (door closed, TICK_DIV=4):
  - Display shows 1:30.
  - magnetron_on is 1 the next cycle.
  - Display shows 1:29 after 4 cycles.
  - Display shows 0:59 after 31 ticks.
- Entry 0:01 → start:
  - Tick 1 gives DONE, done is high for 1 cycle and magnetron_on is 0.
  - stop then returns to IDLE.
- Door opens at 0:45 with the prescaler at 2:
  - PAUSE, magnetron_on is 0 and time holds.
  - Door closes and start is applied: the tick arrives 2 cycles later and shows 0:44.
- Keys 7 then 9:
  - The second key is ignored (7 > 5).
  - Display stays 0:07.
- stop and start in the same cycle during COOK → PAUSE, not COOK.
- With QUICK_START_EN: start in IDLE gives 0:30 in COOK; start in COOK at 9:45 gives 9:59.
